pulse_train_generator: RTL
==========================

PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

Interface
REQ-001 SHALL have parameter N, default 8: per-channel counter, period and width field size in bits.
REQ-002 SHALL have parameter CH, default 4: number of independent channels.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ena, input, CH: per-channel enable.
REQ-006 SHALL have port mode, input, CH: per-channel mode; 0 = periodic, 1 = one-shot.
REQ-007 SHALL have port start, input, CH: per-channel one-shot trigger, sampled on posedge clk.
REQ-008 SHALL have port sync, input, 1: synchronous phase-align strobe for all channels.
REQ-009 SHALL have port ticks, input, CH*N: channel c period field at bits [c*N +: N]; period = ticks+1 cycles.
REQ-010 SHALL have port width, input, CH*N: channel c high-time field at bits [c*N +: N], in cycles.
REQ-011 SHALL have port out, output, CH: per-channel pulse output.
REQ-012 SHALL have port busy, output, CH: channel in RUN state.
REQ-013 SHALL have port wrap, output, CH: one-cycle strobe on a channel's terminal count.

Function (per channel c; each channel independent, sharing only clk, rst, sync)
REQ-014 SHALL hold a 2-state FSM (IDLE, RUN) and an N-bit counter cnt.
REQ-015 IDLE->RUN SHALL occur when ena[c] and (mode[c]==0 or start[c]); cnt <= 0 on entry, so the first RUN cycle has cnt=0.
REQ-016 terminal SHALL be defined as (cnt >= ticks[c]), unsigned compare against the live ticks value.
REQ-017 In RUN, update priority SHALL be: !ena[c] -> IDLE, cnt<=0; else sync -> cnt<=0; else terminal -> cnt<=0; else cnt<=cnt+1.
REQ-018 One-shot: on terminal in RUN with ena[c] high, SHALL go to IDLE unless start[c] is high that cycle; start[c] high -> stay RUN, cnt<=0 (seamless retrigger).
REQ-019 One-shot: start[c] in a non-terminal RUN cycle SHALL be ignored.
REQ-020 Periodic: SHALL stay in RUN while ena[c] is high, wrapping every ticks+1 cycles; start[c] ignored.
REQ-021 mode[c] change SHALL take effect immediately; periodic->one-shot mid-period completes the current period, then goes IDLE.
REQ-022 out[c] SHALL equal (RUN and cnt < width[c]), combinational from registered state; no extra latency.
REQ-023 width=0 SHALL give out[c] constantly 0; width > ticks SHALL give out[c] constantly 1 while in RUN.
REQ-024 wrap[c] SHALL equal (RUN and terminal and ena[c]); busy[c] SHALL equal RUN.
REQ-025 ticks=0 SHALL give period 1: cnt stays 0, wrap[c] high every RUN cycle.
REQ-026 ticks lowered below the current cnt SHALL cause terminal on the very next evaluation: wrap high, cnt<=0.
REQ-027 Counter arithmetic SHALL be N-bit unsigned; cnt never exceeds max(ticks) seen, so there is no overflow path.
REQ-028 Operation across CH and N SHALL be fully parametrised, with no per-channel hand-instantiation.

Reset
REQ-029 rst high SHALL immediately, without a clock edge, force all channels to IDLE, cnt=0, out=0, busy=0, wrap=0.
REQ-030 After rst deasserts, channels SHALL resume per REQ-015 on the next posedge.
REQ-031 No output SHALL glitch high while rst is asserted, regardless of other inputs.

Verification (N=8, CH=4)
REQ-032 Channel 0 periodic, ticks=4, width=2, ena rises at edge 0 -> busy from edge 1; out = 1,1,0,0,0 repeating; wrap high every 5th cycle (cnt=4).
REQ-033 Channel 1 periodic, ticks=4: width=0 -> out always 0; width=5 -> out always 1 while busy; ticks=0, width=1 -> out=1 and wrap=1 every cycle.
REQ-034 Channel 2 one-shot, ticks=3, width=1, single start -> busy 4 cycles, out high cycle 1 only, wrap on cycle 4, then IDLE.
REQ-035 Channel 2 one-shot: start at cnt=1 -> ignored; start at cnt=3 -> continuous 8-cycle busy with wrap at cycles 4 and 8.
REQ-036 Channel 3 periodic, ticks=10; ticks changed to 3 when cnt=6 -> wrap same cycle, cnt=0 next; subsequent period 4.
REQ-037 All channels running at different phases, sync pulsed -> all cnt=0 next cycle; ena[0] dropped -> out[0]=0 and busy[0]=0 next cycle; rst mid-run -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/pulse_train_generator.sv
// Multi-channel pulse train generator: each channel runs a periodic or one-shot
// counter and drives a pulse whose high time and period are set per channel.
module pulse_train_generator #(
    parameter int unsigned N  = 8,
    parameter int unsigned CH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   ena,
    input  logic [CH-1:0]   mode,
    input  logic [CH-1:0]   start,
    input  logic            sync,
    input  logic [CH*N-1:0] ticks,
    input  logic [CH*N-1:0] width,
    output logic [CH-1:0]   out,
    output logic [CH-1:0]   busy,
    output logic [CH-1:0]   wrap
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e         state_q [CH];
    logic [N-1:0]   cnt_q   [CH];
    logic [CH-1:0]  terminal;

    // Outputs are also gated by rst so nothing can flicker high while it is held.
    always_comb begin
        terminal = '0;
        busy     = '0;
        out      = '0;
        wrap     = '0;
        for (int c = 0; c < int'(CH); c++) begin
            terminal[c] = (cnt_q[c] >= ticks[c*N +: N]);
            busy[c]     = !rst && (state_q[c] == StRun);
            out[c]      = busy[c] && (cnt_q[c] < width[c*N +: N]);
            wrap[c]     = busy[c] && terminal[c] && ena[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(CH); c++) begin
                state_q[c] <= StIdle;
                cnt_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < int'(CH); c++) begin
                unique case (state_q[c])
                    StIdle: begin
                        cnt_q[c] <= '0;
                        if (ena[c] && (!mode[c] || start[c])) begin
                            state_q[c] <= StRun;
                        end
                    end
                    StRun: begin
                        if (!ena[c]) begin
                            state_q[c] <= StIdle;
                            cnt_q[c]   <= '0;
                        end else if (sync) begin
                            cnt_q[c] <= '0;
                        end else if (terminal[c]) begin
                            cnt_q[c] <= '0;
                            // A start on the terminal cycle retriggers a one-shot seamlessly.
                            if (mode[c] && !start[c]) begin
                                state_q[c] <= StIdle;
                            end
                        end else begin
                            cnt_q[c] <= cnt_q[c] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
